// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_send transmitter between N_REQ byte producers.
// Optional UART_ARB_LOCK_EN macro enables per-requester grant locking for atomic messages.
module uart_tx_arbiter #(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 115200,
  parameter int N_REQ     = 2,
  parameter int GUARD_CYC = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_lock,
  output logic [N_REQ-1:0]   req_ack,
  output logic               uart_en,
  output logic [7:0]         uart_din,
  output logic               busy
);

  localparam int BPS_CNT   = CLK_FREQ / UART_BPS;
  localparam int FRAME_CYC = BPS_CNT * 10 + GUARD_CYC;
  localparam int IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW        = $clog2(FRAME_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr, win, pick, sel;
  logic            found;
  logic [CW-1:0]   cnt;
  logic            frame_done;
  logic [N_REQ-1:0] ack_nxt;
  logic            en_nxt;
  logic            load_din;

  assign frame_done = (cnt == CW'(FRAME_CYC - 1));

  // First requester at or after the round-robin pointer, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[(int'(rr) + k) % N_REQ]) begin
        found = 1'b1;
        pick  = IW'((int'(rr) + k) % N_REQ);
      end
    end
  end

`ifdef UART_ARB_LOCK_EN
  logic          lock_vld;
  logic [IW-1:0] owner;

  // A requesting lock owner wins regardless of the pointer.
  assign sel = (lock_vld && req[owner]) ? owner : pick;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      lock_vld <= 1'b0;
      owner    <= '0;
    end else if (state == S_IDLE) begin
      if (found) begin
        lock_vld <= req_lock[sel];
        owner    <= sel;
      end else begin
        lock_vld <= 1'b0;
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign sel         = pick;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (found) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_WAIT;
      S_WAIT:  if (frame_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack_nxt  = '0;
    en_nxt   = 1'b0;
    load_din = 1'b0;
    busy     = (state != S_IDLE);
    if (state == S_IDLE && found) begin
      ack_nxt[sel] = 1'b1;
      load_din     = 1'b1;
    end
    if (state == S_LOAD) en_nxt = 1'b1;
  end

  // Registered outputs: ack lands in LOAD, the send strobe in the first WAIT cycle.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      req_ack  <= '0;
      uart_en  <= 1'b0;
      uart_din <= 8'h00;
      rr       <= '0;
      win      <= '0;
      cnt      <= '0;
    end else begin
      req_ack <= ack_nxt;
      uart_en <= en_nxt;
      if (load_din) begin
        uart_din <= req_data[8*sel +: 8];
        win      <= sel;
      end
      if (state == S_LOAD) begin
        cnt <= '0;
        rr  <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
      end else if (state == S_WAIT && !frame_done) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
